// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Core stores to TXDATA queue bytes in a circular FIFO; a four-state
// serialiser drains the FIFO and shifts each byte out LSB first on tx_o.
// Register reads are combinational so the single-cycle load path sees them
// in the same cycle.
//
// Ports:
//   clk_i   system clock, rising edge
//   rst_i   asynchronous active-low reset
//   sel_i   peripheral select from the address decoder
//   addr_i  byte address; addr_i[3:2] selects TXDATA/STATUS/BAUDDIV/reserved
//   data_i  store data
//   we_i    store enable
//   data_o  combinational read data (zero when not selected)
//   tx_o    registered serial output, idles high
//   irq_o   level interrupt, high while the FIFO is empty

module uart_tx_mmio #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 868
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        we_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [1:0] reg_sel;
    logic       wr_en;
    logic       push;
    logic       push_ok;
    logic       ovf_set;
    logic       ovf_clr;
    logic       div_wr;

    assign reg_sel = addr_i[3:2];
    assign wr_en   = sel_i & we_i;
    assign push    = wr_en && (reg_sel == REG_TXDATA);
    assign ovf_clr = wr_en && (reg_sel == REG_STATUS) && data_i[3];
    assign div_wr  = wr_en && (reg_sel == REG_BAUDDIV);

    // Bits of the bus that no register decodes.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             empty;
    logic             pop;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // Fullness is judged before the edge, so a push into a full FIFO is
    // lost even when the serialiser pops on the same edge.
    assign push_ok = push & ~full;
    assign ovf_set = push & full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Overflow flag and baud divisor
    // ------------------------------------------------------------------
    logic        ovf_q, ovf_d;
    logic [15:0] div_q, div_d;

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
        div_d = div_q;
        if (div_wr) begin
            // A divisor of 0 would never end a bit; clamp to one cycle.
            div_d = (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_q <= 1'b0;
            div_q <= 16'(DIV_RESET);
        end else begin
            ovf_q <= ovf_d;
            div_q <= div_d;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        bit_end;

    // The divisor is read live, so lowering it below the running count
    // simply ends the current bit on the next edge.
    assign bit_end = (cnt_q >= (div_q - 16'd1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        // Next bit is what lands in shift[0] after the shift.
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------
    logic       busy;
    logic [3:0] count4;

    assign busy   = (state_q != ST_IDLE) || !empty;
    assign count4 = 4'(count_q);

    always_comb begin
        data_o = 32'h0;
        if (sel_i) begin
            case (reg_sel)
                REG_STATUS:  data_o = {24'h0, count4, ovf_q, empty, full, busy};
                REG_BAUDDIV: data_o = {16'h0, div_q};
                default:     data_o = 32'h0;
            endcase
        end
    end

    assign tx_o  = tx_q;
    assign irq_o = empty;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard bench for uart_tx_mmio

module tb_uart_tx_mmio;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        we = 1'b0;
    logic [31:0] data_o;
    logic        tx_o;
    logic        irq_o;

    uart_tx_mmio #(.FIFO_DEPTH(DEPTH), .DIV_RESET(868)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .sel_i (sel),
        .addr_i(addr),
        .data_i(wdata),
        .we_i  (we),
        .data_o(data_o),
        .tx_o  (tx_o),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         model_div = 868;
    bit         mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] ra, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = {28'h0, ra, 2'b00}; wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] ra, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = {28'h0, ra, 2'b00};
        #1;
        d = data_o;
        sel = 1'b0;
    endtask

    // Push a byte the bench expects to be accepted and transmitted.
    task automatic send(input logic [7:0] b);
        exp_q.push_back(b);
        bus_write(2'd0, {24'h0, b});
    endtask

    task automatic set_div(input int d);
        bus_write(2'd2, 32'(d));
        model_div = (d == 0) ? 1 : d;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] s;
        int n;
        n = 0;
        s = 32'h1;
        while (s[0] && n < budget) begin
            bus_read(2'd1, s);
            n++;
        end
        if (s[0]) chk("idle_timeout", s, 32'h0);
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_o !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (tx_o !== 1'b0) chk("start_timeout", {31'h0, tx_o}, 32'h0);
    endtask

    // Cycles until tx_o changes, starting at the current negedge.
    task automatic run_len(output int n);
        logic v;
        v = tx_o;
        n = 0;
        while (tx_o === v && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Line monitor: each frame seen on tx_o is compared, cycle by cycle,
    // against the 8N1 waveform of the oldest byte in the scoreboard.
    initial begin
        logic       prev_tx;
        bit         in_frame;
        bit         gap_pending;
        int         off, fdiv, errs, gap_cnt, k;
        logic [7:0] eb;
        logic       expb;
        prev_tx = 1'b1; in_frame = 0; gap_pending = 0;
        off = 0; fdiv = 1; errs = 0; gap_cnt = 0; eb = 8'h0;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                in_frame = 0;
                gap_pending = 0;
            end else if (in_frame) begin
                off++;
                k = off / fdiv;
                if (k == 0)      expb = 1'b0;
                else if (k == 9) expb = 1'b1;
                else             expb = eb[k-1];
                if (tx_o !== expb) errs++;
                if (off == 10 * fdiv - 1) begin
                    if (errs != 0) $display("FAIL frame byte %h: %0d bad bit-cycles", eb, errs);
                    chk("frame_bit_errors", 32'(errs), 32'h0);
                    in_frame = 0;
                    gap_cnt = 0;
                    gap_pending = (exp_q.size() > 0);
                end
            end else if (prev_tx === 1'b1 && tx_o === 1'b0) begin
                if (gap_pending) chk("interframe_gap", 32'(gap_cnt), 32'd1);
                gap_pending = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(exp_q.size()), 32'd1);
                end else begin
                    eb = exp_q.pop_front();
                    in_frame = 1;
                    off = 0;
                    fdiv = model_div;
                    errs = 0;
                end
            end else begin
                gap_cnt++;
                if (gap_pending && gap_cnt > 1) begin
                    chk("interframe_gap", 32'(gap_cnt), 32'd1);
                    gap_pending = 0;
                end
            end
            prev_tx = tx_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int n, d, c, lows;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'h0, tx_o}, 32'h1);
        chk("reset_irq", {31'h0, irq_o}, 32'h1);
        rst_n = 1'b1;
        bus_read(2'd1, r); chk("reset_status", r, 32'h4);
        bus_read(2'd2, r); chk("reset_bauddiv", r, 32'd868);
        mon_en = 1'b1;

        // Single byte, latency and 40-cycle frame
        set_div(4);
        bus_read(2'd2, r); chk("bauddiv_4", r, 32'd4);
        send(8'hA5);
        @(negedge clk); chk("latency_tx_high", {31'h0, tx_o}, 32'h1);
        @(negedge clk); chk("latency_tx_low", {31'h0, tx_o}, 32'h0);
        wait_idle(100);
        bus_read(2'd1, r); chk("status_after_a5", r, 32'h4);

        // Nine back-to-back pushes fit thanks to the first pop; tenth overflows
        set_div(2);
        for (int i = 0; i < 9; i++) send(8'(8'h30 + i));
        bus_read(2'd1, r); chk("status_nine", r, 32'h83);
        chk("irq_not_empty", {31'h0, irq_o}, 32'h0);
        bus_write(2'd0, 32'h0000_00EE);
        bus_read(2'd1, r); chk("status_overflow", r, 32'h8B);
        wait_idle(400);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        bus_read(2'd1, r); chk("status_ovf_idle", r, 32'hC);
        bus_write(2'd1, 32'h0);
        bus_read(2'd1, r); chk("ovf_write0_keeps", r, 32'hC);
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, r); chk("ovf_cleared", r, 32'h4);
        chk("irq_empty", {31'h0, irq_o}, 32'h1);

        // Randomized bursts
        for (int it = 0; it < 6; it++) begin
            d = $urandom_range(1, 6);
            n = $urandom_range(1, DEPTH);
            set_div(d);
            bus_read(2'd2, r); chk("rand_bauddiv", r, 32'(d));
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                send(b);
            end
            c = (n == 1) ? 1 : n - 1;
            bus_read(2'd1, r); chk("rand_status", r, 32'((c << 4) | 1));
            wait_idle(n * (10 * d + 1) + 20);
            bus_read(2'd1, r); chk("rand_status_idle", r, 32'h4);
        end

        // Divisor 0 stored as 1: ten-cycle frame
        set_div(0);
        bus_read(2'd2, r); chk("bauddiv_zero", r, 32'd1);
        send(8'h3C);
        wait_idle(40);

        // Divisor raised mid-DATA
        mon_en = 1'b0;
        set_div(4);
        bus_write(2'd0, 32'h0000_00AA);
        wait_start(20);
        repeat (5) @(negedge clk);
        set_div(16);
        @(negedge clk);
        run_len(n);
        run_len(n); chk("slow_bit1_len", 32'(n), 32'd16);
        run_len(n); chk("slow_bit2_len", 32'(n), 32'd16);
        wait_idle(400);
        mon_en = 1'b1;

        // Unselected write and reserved offset
        set_div(3);
        @(negedge clk);
        sel = 1'b0; we = 1'b1; addr = 32'h0; wdata = 32'h55;
        #1 chk("unsel_data_o", data_o, 32'h0);
        @(posedge clk); #1 we = 1'b0;
        repeat (5) @(negedge clk);
        bus_read(2'd1, r); chk("unsel_no_push", r, 32'h4);
        @(negedge clk);
        sel = 1'b0; addr = 32'h8;
        #1 chk("unsel_read_div", data_o, 32'h0);
        bus_read(2'd3, r); chk("reserved_read", r, 32'h0);
        bus_write(2'd3, 32'h1234);
        bus_read(2'd2, r); chk("reserved_write_ignored", r, 32'd3);
        bus_read(2'd0, r); chk("txdata_read", r, 32'h0);

        // Reset mid-frame
        mon_en = 1'b0;
        set_div(4);
        bus_write(2'd0, 32'h0);
        bus_write(2'd0, 32'h0);
        wait_start(20);
        repeat (8) @(negedge clk);
        chk("pre_reset_tx", {31'h0, tx_o}, 32'h0);
        chk("pre_reset_irq", {31'h0, irq_o}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_tx", {31'h0, tx_o}, 32'h1);
        chk("reset_async_irq", {31'h0, irq_o}, 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_div = 868;
        bus_read(2'd1, r); chk("post_reset_status", r, 32'h4);
        bus_read(2'd2, r); chk("post_reset_bauddiv", r, 32'd868);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_o !== 1'b1) lows++;
        end
        chk("post_reset_line_idle", 32'(lows), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
